// File: rtl/lcd_cmd_seq.sv
// lcd_cmd_seq -- command sequencer between a host command source and LCD_CTRL.
// Buffers up to DEPTH 4-bit commands in a circular FIFO. Issues them one at a
// time with a single-cycle cmd_valid strobe, and waits for busy to drop between
// commands. After the final Write command (0) it waits for LCD_CTRL's done
// pulse. A hung LCD_CTRL is reported through a sticky timeout flag.
// Optional build macro: LCD_SEQ_CNT_EN enables the `issued` command counter;
// when it is undefined, `issued` is tied to zero.
module lcd_cmd_seq #(
  parameter int DEPTH   = 8,    // FIFO entries, power of two, >= 2
  parameter int TIMEOUT = 255   // max cycles in WAIT or DRAIN, 1..255
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clr,
  input  logic [3:0]               in_cmd,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [3:0]               cmd,
  output logic                     cmd_valid,
  input  logic                     busy,
  input  logic                     done,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     fin,
  output logic                     err_to,
  output logic [7:0]               issued
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  // timer_q holds the number of cycles already spent in WAIT/DRAIN, so the
  // cycle that sees TIMEOUT-1 is the TIMEOUT-th cycle in that state.
  localparam logic [7:0]  TO_LAST  = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_SETTLE, S_WAIT, S_DRAIN, S_FIN, S_HALT
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [3:0]    cmd_q, cmd_d;
  logic [7:0]    timer_q, timer_d;
  logic [3:0]    mem_q [DEPTH];

  logic full;
  logic push;
  logic pop;

  // Handshake and pop qualification; all derived from registered state.
  assign full     = (count_q == FULL_CNT);
  assign in_ready = !full && (state_q != S_FIN) && (state_q != S_HALT);
  assign push     = in_valid && in_ready && !clr;
  assign pop      = (state_q == S_IDLE) && (count_q != '0) && !busy && !clr;

  assign cmd       = cmd_q;
  assign cmd_valid = (state_q == S_ISSUE);
  assign count     = count_q;
  assign fin       = (state_q == S_FIN);
  assign err_to    = (state_q == S_HALT);

  // FIFO storage write port.
  // NOTE: the storage array has no reset; the pointers and count define which
  // entries are valid, so flushing them discards the contents.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_cmd;
  end

  // FIFO pointer and occupancy next-state.
  // NOTE: every variable gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Sequencer next-state, command latch and WAIT/DRAIN timer.
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    timer_d = timer_q;
    if (clr) begin
      state_d = S_IDLE;
      timer_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pop) begin
            cmd_d   = mem_q[rd_ptr_q];
            state_d = S_ISSUE;
          end
        end
        S_ISSUE:  state_d = S_SETTLE;
        S_SETTLE: begin
          timer_d = '0;
          state_d = (cmd_q == 4'd0) ? S_DRAIN : S_WAIT;
        end
        S_WAIT: begin
          if (!busy)                   state_d = S_IDLE;
          else if (timer_q == TO_LAST) state_d = S_HALT;
          else                         timer_d = timer_q + 8'd1;
        end
        S_DRAIN: begin
          if (done)                    state_d = S_FIN;
          else if (timer_q == TO_LAST) state_d = S_HALT;
          else                         timer_d = timer_q + 8'd1;
        end
        S_FIN:   state_d = S_FIN;
        S_HALT:  state_d = S_HALT;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State, pointer, command and timer registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      cmd_q    <= 4'd0;
      timer_q  <= 8'd0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      cmd_q    <= cmd_d;
      timer_q  <= timer_d;
    end
  end

`ifdef LCD_SEQ_CNT_EN
  logic [7:0] issued_q, issued_d;

  // Issue counter next-state: counts ISSUE cycles, wraps 255 -> 0.
  always_comb begin
    issued_d = issued_q;
    if (clr)                       issued_d = 8'd0;
    else if (state_q == S_ISSUE)   issued_d = issued_q + 8'd1;
  end

  // Issue counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) issued_q <= 8'd0;
    else        issued_q <= issued_d;
  end

  assign issued = issued_q;
`else
  assign issued = 8'd0;
`endif

endmodule

// File: tb/tb_lcd_cmd_seq.sv
// tb_lcd_cmd_seq -- directed, table-driven bench for lcd_cmd_seq.
// Runs with DEPTH=8, TIMEOUT=10. A small LCD model (busy for 3 cycles per
// issue, done pulse after a Write) can be switched in; otherwise busy/done are
// driven by hand.
module tb_lcd_cmd_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr;
  logic [3:0] in_cmd;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] cmd;
  logic       cmd_valid;
  logic       busy;
  logic       done;
  logic [3:0] count;
  logic       fin;
  logic       err_to;
  logic [7:0] issued;

  logic       model_en;
  logic       man_busy;
  logic       man_done;
  int         bcnt = 0;
  int         dcnt = 0;
  int         pulses = 0;
  logic [3:0] got_q [$];

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0] in_cmd;
    logic       in_valid;
    logic       exp_ready;
    logic [3:0] exp_cmd;
    logic [3:0] exp_count;
  } vec_t;

  vec_t tbl1 [9];
  vec_t tbl2 [10];

  always #5 clk = ~clk;

  assign busy = model_en ? (bcnt != 0) : man_busy;
  assign done = model_en ? (dcnt == 1) : man_done;

  lcd_cmd_seq #(.DEPTH(8), .TIMEOUT(10)) dut (
    .clk      (clk),
    .reset    (rst_n),
    .clr      (clr),
    .in_cmd   (in_cmd),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .cmd      (cmd),
    .cmd_valid(cmd_valid),
    .busy     (busy),
    .done     (done),
    .count    (count),
    .fin      (fin),
    .err_to   (err_to),
    .issued   (issued)
  );

  // LCD model and issue monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (cmd_valid)          bcnt <= 3;
    else if (bcnt > 0)      bcnt <= bcnt - 1;
    if (cmd_valid && cmd == 4'd0) dcnt <= 5;
    else if (dcnt > 0)            dcnt <= dcnt - 1;
    if (cmd_valid) begin
      pulses <= pulses + 1;
      got_q.push_back(cmd);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] c);
    in_cmd   = c;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  initial begin
    int p0;
    int gi;
    int sent;
    int cyc;
    logic [3:0] exp_seq [4];
    logic [7:0] exp_iss;

    // 9 pushes with busy high: 8 accepted, the 9th sees in_ready=0.
    tbl1[0] = '{4'd1, 1'b1, 1'b1, 4'd0, 4'd1};
    tbl1[1] = '{4'd2, 1'b1, 1'b1, 4'd0, 4'd2};
    tbl1[2] = '{4'd3, 1'b1, 1'b1, 4'd0, 4'd3};
    tbl1[3] = '{4'd4, 1'b1, 1'b1, 4'd0, 4'd4};
    tbl1[4] = '{4'd5, 1'b1, 1'b1, 4'd0, 4'd5};
    tbl1[5] = '{4'd6, 1'b1, 1'b1, 4'd0, 4'd6};
    tbl1[6] = '{4'd7, 1'b1, 1'b1, 4'd0, 4'd7};
    tbl1[7] = '{4'd8, 1'b1, 1'b1, 4'd0, 4'd8};
    tbl1[8] = '{4'd9, 1'b1, 1'b0, 4'd0, 4'd8};
    // Pop rounds with the FIFO preloaded 1..4: push during pop keeps count 4,
    // pointers wrap past 8, then the tail drains in order.
    tbl2[0] = '{4'd5,  1'b1, 1'b1, 4'd1,  4'd4};
    tbl2[1] = '{4'd6,  1'b1, 1'b1, 4'd2,  4'd4};
    tbl2[2] = '{4'd7,  1'b1, 1'b1, 4'd3,  4'd4};
    tbl2[3] = '{4'd8,  1'b1, 1'b1, 4'd4,  4'd4};
    tbl2[4] = '{4'd9,  1'b1, 1'b1, 4'd5,  4'd4};
    tbl2[5] = '{4'd10, 1'b1, 1'b1, 4'd6,  4'd4};
    tbl2[6] = '{4'd0,  1'b0, 1'b1, 4'd7,  4'd3};
    tbl2[7] = '{4'd0,  1'b0, 1'b1, 4'd8,  4'd2};
    tbl2[8] = '{4'd0,  1'b0, 1'b1, 4'd9,  4'd1};
    tbl2[9] = '{4'd0,  1'b0, 1'b1, 4'd10, 4'd0};

    rst_n = 1'b0; clr = 1'b0; in_cmd = 4'd0; in_valid = 1'b0;
    man_busy = 1'b1; man_done = 1'b0; model_en = 1'b0;

    // Reset values.
    #12;
    check("rst_cmd", cmd, 0);
    check("rst_cmd_valid", cmd_valid, 0);
    check("rst_count", count, 0);
    check("rst_fin", fin, 0);
    check("rst_err_to", err_to, 0);
    check("rst_issued", issued, 0);
    check("rst_in_ready", in_ready, 1);
    @(negedge clk) rst_n = 1'b1;

    // Fill to full with busy stuck high.
    p0 = pulses;
    for (int i = 0; i < 9; i++) begin
      in_cmd   = tbl1[i].in_cmd;
      in_valid = tbl1[i].in_valid;
      check("t1_ready", in_ready, tbl1[i].exp_ready);
      step();
      check("t1_count", count, tbl1[i].exp_count);
    end
    in_valid = 1'b0;
    check("t1_no_issue", pulses - p0, 0);
    do_clr();
    check("t1_clr_count", count, 0);
    check("t1_clr_ready", in_ready, 1);

    // Simultaneous push/pop across the pointer wrap.
    push(4'd1); push(4'd2); push(4'd3); push(4'd4);
    check("t2_pre_count", count, 4);
    for (int i = 0; i < 10; i++) begin
      man_busy = 1'b0;
      in_cmd   = tbl2[i].in_cmd;
      in_valid = tbl2[i].in_valid;
      step();
      in_valid = 1'b0;
      check("t2_cmd_valid", cmd_valid, 1);
      check("t2_cmd", cmd, tbl2[i].exp_cmd);
      check("t2_count", count, tbl2[i].exp_count);
      man_busy = 1'b1;
      step();
      step();
      man_busy = 1'b0;
      step();
    end
`ifdef LCD_SEQ_CNT_EN
    exp_iss = 8'd10;
`else
    exp_iss = 8'd0;
`endif
    check("t2_issued", issued, exp_iss);

    // Full sequence 1,2,3,0 against the LCD model.
    do_clr();
    model_en = 1'b1;
    p0 = pulses;
    gi = got_q.size();
    in_cmd = 4'd1; in_valid = 1'b1;
    step();
    check("t3_lat_no_strobe", cmd_valid, 0);
    check("t3_lat_count", count, 1);
    in_cmd = 4'd2;
    step();
    check("t3_lat_strobe", cmd_valid, 1);
    check("t3_lat_cmd", cmd, 1);
    check("t3_pushpop_count", count, 1);
    in_cmd = 4'd3;
    step();
    in_cmd = 4'd0;
    step();
    in_valid = 1'b0;
    check("t3_queued", count, 3);
    for (int k = 0; k < 300 && !fin; k++) step();
    check("t3_fin", fin, 1);
    check("t3_pulses", pulses - p0, 4);
    exp_seq[0] = 4'd1; exp_seq[1] = 4'd2; exp_seq[2] = 4'd3; exp_seq[3] = 4'd0;
    for (int k = 0; k < 4; k++) begin
      if (got_q.size() > gi + k) check("t3_order", got_q[gi+k], exp_seq[k]);
      else                       check("t3_order_missing", 99, exp_seq[k]);
    end
`ifdef LCD_SEQ_CNT_EN
    exp_iss = 8'd4;
`else
    exp_iss = 8'd0;
`endif
    check("t3_issued", issued, exp_iss);
    check("t3_count", count, 0);
    check("t3_fin_ready", in_ready, 0);
    repeat (3) step();
    check("t3_fin_sticky", fin, 1);

    // Timeout with busy stuck after issuing command 3 (TIMEOUT=10).
    model_en = 1'b0;
    man_busy = 1'b0;
    do_clr();
    check("t4_fin_cleared", fin, 0);
    p0 = pulses;
    push(4'd3);
    step();
    check("t4_strobe", cmd_valid, 1);
    check("t4_cmd", cmd, 3);
    man_busy = 1'b1;
    in_cmd = 4'd5; in_valid = 1'b1;
    step();
    in_cmd = 4'd6;
    step();
    in_valid = 1'b0;
    check("t4_count", count, 2);
    repeat (9) step();
    check("t4_err_before", err_to, 0);
    step();
    check("t4_err_at_10", err_to, 1);
    check("t4_halt_ready", in_ready, 0);
    in_cmd = 4'd7; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("t4_push_dropped", count, 2);
    man_busy = 1'b0;
    repeat (10) step();
    check("t4_no_issue", pulses - p0, 1);
    check("t4_err_sticky", err_to, 1);
    do_clr();
    check("t4_clr_err", err_to, 0);
    check("t4_clr_count", count, 0);
    check("t4_clr_ready", in_ready, 1);
    push(4'd7);
    step();
    check("t4_idle_strobe", cmd_valid, 1);
    check("t4_idle_cmd", cmd, 7);
    repeat (3) step();

    // Asynchronous reset while in WAIT with count=5.
    do_clr();
    in_cmd = 4'd1; in_valid = 1'b1;
    step();
    for (int c = 2; c <= 6; c++) begin
      in_cmd = 4'(c);
      step();
      man_busy = 1'b1;
    end
    in_valid = 1'b0;
    check("t5_count_pre", count, 5);
    #2 rst_n = 1'b0;
    #1;
    check("t5_cmd_valid", cmd_valid, 0);
    check("t5_count", count, 0);
    check("t5_issued", issued, 0);
    check("t5_fin", fin, 0);
    check("t5_cmd", cmd, 0);
    check("t5_ready", in_ready, 1);
    man_busy = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    p0 = pulses;
    repeat (5) step();
    check("t5_discarded", pulses - p0, 0);

    // 300 non-Write commands: issued wraps to 44.
    do_clr();
    p0   = pulses;
    sent = 0;
    cyc  = 0;
    while (sent < 300 && cyc < 5000) begin
      in_cmd   = 4'((sent % 15) + 1);
      in_valid = 1'b1;
      if (in_ready) sent++;
      step();
      cyc++;
    end
    in_valid = 1'b0;
    while ((pulses - p0) < 300 && cyc < 5000) begin
      step();
      cyc++;
    end
    repeat (4) step();
    check("t6_sent", sent, 300);
    check("t6_pulses", pulses - p0, 300);
`ifdef LCD_SEQ_CNT_EN
    exp_iss = 8'd44;
`else
    exp_iss = 8'd0;
`endif
    check("t6_issued", issued, exp_iss);
    check("t6_count", count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
